// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the multiplexed seven-segment display path.
//   SEG_OFF   : all segments dark (active-low)
//   SEG_GLYPH : hex glyphs 0-F, active-low {dp, g, f, e, d, c, b, a}, dp bit off
//   sel_w()   : width of a binary digit index, never less than 1
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index 15 is leftmost in the packed concatenation.
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  function automatic int sel_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational hex digit to active-low segment pattern.
//   hex_i   : 4-bit digit value
//   dp_i    : 1 = decimal point lit
//   blank_i : 1 = whole digit dark (overrides value and dp)
//   seg_o   : active-low {dp, g, f, e, d, c, b, a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      seg_o = {~dp_i, SEG_GLYPH[hex_i][6:0]};
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- tear-free multiplexed seven-segment display controller.
// A loaded word waits in a pending register and is copied to the displayed
// image only at a frame boundary; digits are then scanned one at a time.
//   clk_100M, rst_n : clock, asynchronous active-low reset
//   load            : capture data_in / dp_in / blank_in into pending
//   data_in         : DIGITS hex nibbles, digit 0 in the low nibble
//   dp_in, blank_in : per-digit decimal point / dark control
//   busy            : pending word not yet committed
//   upd_done        : one-cycle pulse the cycle after a commit
//   frame_tick      : combinational pulse in the frame-boundary cycle
//   seg_cs          : binary index of the driven digit (registered)
//   seg_data        : active-low segments of that digit (registered)
// Build option: define SEG7_LZS_EN for leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS  = 6,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int SEL_W   = sel_w(DIGITS)
) (
  input  logic                clk_100M,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  output logic                busy,
  output logic                upd_done,
  output logic                frame_tick,
  output logic [SEL_W-1:0]    seg_cs,
  output logic [7:0]          seg_data
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    seg_cs_q, seg_cs_d;
  logic [7:0]          seg_data_q, seg_data_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic                busy_q, busy_d;
  logic                upd_done_q, upd_done_d;

  logic                scan_en, frame_bd, commit;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          sel_hex;
  logic                sel_dp, sel_blank;
  logic [7:0]          dec_seg;

  always_comb begin
    scan_en  = (cnt_q == CNT_LAST);
    frame_bd = scan_en && (idx_q == IDX_LAST);
    commit   = frame_bd && busy_q;

    cnt_d = scan_en ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (scan_en) begin
      idx_d = frame_bd ? '0 : idx_q + 1'b1;
    end

    // Commit reads pending before this edge's load overwrites it.
    act_data_d  = commit ? pend_data_q  : act_data_q;
    act_dp_d    = commit ? pend_dp_q    : act_dp_q;
    act_blank_d = commit ? pend_blank_q : act_blank_q;

    pend_data_d  = load ? data_in  : pend_data_q;
    pend_dp_d    = load ? dp_in    : pend_dp_q;
    pend_blank_d = load ? blank_in : pend_blank_q;

    busy_d     = load | (busy_q & ~commit);
    upd_done_d = commit;
  end

`ifdef SEG7_LZS_EN
  logic lz_lead;

  // Walk down from the top digit; suppression holds while digits are zero
  // with dp off. Digit 0 is always shown.
  always_comb begin
    lz_mask = '0;
    lz_lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz_lead    = lz_lead & (act_data_d[4*k +: 4] == 4'h0) & ~act_dp_d[k];
      lz_mask[k] = lz_lead;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Decode the digit about to be selected, from the post-commit image, so the
  // first digit of a new frame already shows the new word.
  always_comb begin
    sel_hex   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == SEL_W'(k)) begin
        sel_hex   = act_data_d[4*k +: 4];
        sel_dp    = act_dp_d[k];
        sel_blank = act_blank_d[k] | lz_mask[k];
      end
    end
  end

  seg7_decode u_decode (
    .hex_i   (sel_hex),
    .dp_i    (sel_dp),
    .blank_i (sel_blank),
    .seg_o   (dec_seg)
  );

  assign seg_cs_d   = scan_en ? idx_d   : seg_cs_q;
  assign seg_data_d = scan_en ? dec_seg : seg_data_q;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_cs_q     <= '0;
      seg_data_q   <= SEG_OFF;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      busy_q       <= 1'b0;
      upd_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_cs_q     <= seg_cs_d;
      seg_data_q   <= seg_data_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      busy_q       <= busy_d;
      upd_done_q   <= upd_done_d;
    end
  end

  assign busy       = busy_q;
  assign upd_done   = upd_done_q;
  assign frame_tick = frame_bd;
  assign seg_cs     = seg_cs_q;
  assign seg_data   = seg_data_q;

endmodule
